// File: rtl/ingre_count_anim_pkg.sv
// Shared types and screen constants for the ingredient tracker family.
// Used by the count animators and their glyph renderers.
package ingre_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    SWAP      = 2'd2,
    MOVE_DOWN = 2'd3
  } anim_state_e;

  localparam int SCREEN_W = 96;
  localparam int SCREEN_H = 64;
  localparam int GLYPH_H  = 5;
  localparam int GLYPH_X0 = 80;

  localparam logic [15:0] BG_COLOUR = 16'hFDDB;

endpackage

// File: rtl/ingre_count_anim_if.sv
// Event inputs and renderer outputs of one ingredient tracker.
// The master side is game logic; the slave side is the animator.
interface ingre_count_anim_if;

  logic       collect;
  logic       clear;
  logic [6:0] y_pos;
  logic       count;
  logic       busy;

  modport master (
    output collect,
    output clear,
    input  y_pos,
    input  count,
    input  busy
  );

  modport slave (
    input  collect,
    input  clear,
    output y_pos,
    output count,
    output busy
  );

endinterface

// File: rtl/ingre_count_anim_frame_step_div.sv
// Frame-rate divider: one-cycle step every FRAME_DIV enabled cycles.
// Shared by all ingredient trackers.
module frame_step_div #(
  parameter int FRAME_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic sync_clr_i,
  output logic step_o
);

  localparam int W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(FRAME_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Step on the terminal count, wrap to zero; a clear holds it at zero.
  always_comb begin
    step_o = en_i && !sync_clr_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (sync_clr_i || step_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ingre_count_anim.sv
// Collected-flag owner and bounce animation for one ingredient digit.
// Drives the digit and its top row straight into the glyph renderer.
module ingre_count_anim
  import ingre_pkg::*;
#(
  parameter int FRAME_DIV = 1_000_000,
  parameter int Y_REST    = 40,
  parameter int RISE      = 3
) (
  input  logic               clk,
  input  logic               reset,
  ingre_count_anim_if.slave  bus
);

  localparam logic [6:0] Y_BOT  = 7'(Y_REST);
  localparam logic [6:0] Y_TOP1 = 7'(Y_REST - RISE + 1);
  localparam logic [6:0] Y_BOT1 = 7'(Y_REST - 1);

  anim_state_e state_q;
  logic [6:0]  y_q;
  logic        count_q;
  logic        busy_q;
  logic        pend_q;

  logic        div_en;
  logic        div_clr;
  logic        step;
  logic        start;

  // Divider only runs while moving; idle/swap park it at zero.
  always_comb begin
    div_en  = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
    div_clr = !div_en;
    start   = !bus.clear && (bus.collect || pend_q);
  end

  frame_step_div #(
    .FRAME_DIV (FRAME_DIV)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .en_i       (div_en),
    .sync_clr_i (div_clr),
    .step_o     (step)
  );

  // Animation FSM with registered renderer outputs; clear always wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= Y_BOT;
      count_q <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      if (bus.clear) begin
        count_q <= 1'b0;
        pend_q  <= 1'b0;
      end else if (bus.collect && state_q != IDLE) begin
        pend_q  <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          busy_q <= start;
          y_q    <= Y_BOT;
          if (start) begin
            state_q <= MOVE_UP;
            pend_q  <= 1'b0;
          end
        end
        MOVE_UP: begin
          if (step) begin
            y_q <= y_q - 7'd1;
            if (y_q == Y_TOP1) begin
              state_q <= SWAP;
            end
          end
        end
        SWAP: begin
          if (!bus.clear) begin
            count_q <= ~count_q;
          end
          state_q <= MOVE_DOWN;
        end
        MOVE_DOWN: begin
          if (step) begin
            y_q <= y_q + 7'd1;
            if (y_q == Y_BOT1) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.y_pos = y_q;
  assign bus.count = count_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_ingre_count_anim.sv
// Directed bench for ingre_count_anim (FRAME_DIV=4, Y_REST=40, RISE=3).
// Samples on the falling edge; e counts rising edges since the last collect.
module tb_ingre_count_anim;

  logic clk;
  logic reset;
  int   e;
  int   n_run;
  int   n_fail;

  ingre_count_anim_if bus ();

  ingre_count_anim #(
    .FRAME_DIV (4),
    .Y_REST    (40),
    .RISE      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (e=%0d)", tag, got, exp, e);
    end
  endtask

  task automatic at(input int k);
    while (e < k) begin
      @(negedge clk);
      e++;
    end
  endtask

  // Collect sampled at the next rising edge, which becomes edge 0.
  task automatic go();
    bus.collect = 1'b1;
    @(negedge clk);
    bus.collect = 1'b0;
    e = 0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    e      = 0;
    bus.collect = 1'b0;
    bus.clear   = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_y", int'(bus.y_pos), 40);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic animation
    go();
    chk("a_busy0", int'(bus.busy), 1);
    chk("a_y0", int'(bus.y_pos), 40);
    at(1);  chk("a_busy1", int'(bus.busy), 1);
    at(3);  chk("a_y3", int'(bus.y_pos), 40);
    at(4);  chk("a_y4", int'(bus.y_pos), 39);
    at(8);  chk("a_y8", int'(bus.y_pos), 38);
    at(12); chk("a_y12", int'(bus.y_pos), 37);
    chk("a_cnt12", int'(bus.count), 0);
    at(13); chk("a_cnt13", int'(bus.count), 1);
    at(14); chk("a_cnt14", int'(bus.count), 1);
    at(16); chk("a_y16", int'(bus.y_pos), 37);
    at(17); chk("a_y17", int'(bus.y_pos), 38);
    at(21); chk("a_y21", int'(bus.y_pos), 39);
    at(25); chk("a_y25", int'(bus.y_pos), 40);
    chk("a_busy25", int'(bus.busy), 1);
    at(26); chk("a_busy26", int'(bus.busy), 0);
    at(27); chk("a_busy27", int'(bus.busy), 0);
    chk("a_y27", int'(bus.y_pos), 40);

    // Reset mid MOVE_UP with count=1
    go();
    at(8);
    chk("r_y8", int'(bus.y_pos), 38);
    chk("r_cnt8", int'(bus.count), 1);
    #2 reset = 1'b1;
    #1;
    chk("r_y", int'(bus.y_pos), 40);
    chk("r_count", int'(bus.count), 0);
    chk("r_busy", int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("r_idle_y", int'(bus.y_pos), 40);
      chk("r_idle_busy", int'(bus.busy), 0);
    end

    // Clear during MOVE_DOWN
    go();
    at(13); chk("d_cnt13", int'(bus.count), 1);
    at(17);
    chk("d_y17", int'(bus.y_pos), 38);
    bus.clear = 1'b1;
    at(18);
    bus.clear = 1'b0;
    chk("d_cnt18", int'(bus.count), 0);
    at(21); chk("d_y21", int'(bus.y_pos), 39);
    at(25); chk("d_y25", int'(bus.y_pos), 40);
    chk("d_busy25", int'(bus.busy), 1);
    at(26); chk("d_busy26", int'(bus.busy), 0);
    chk("d_cnt26", int'(bus.count), 0);

    // Clear coincident with SWAP
    go();
    at(12);
    chk("s_y12", int'(bus.y_pos), 37);
    bus.clear = 1'b1;
    at(13);
    bus.clear = 1'b0;
    chk("s_cnt13", int'(bus.count), 0);
    at(14); chk("s_cnt14", int'(bus.count), 0);
    at(17); chk("s_y17", int'(bus.y_pos), 38);
    at(25); chk("s_y25", int'(bus.y_pos), 40);
    at(26); chk("s_busy26", int'(bus.busy), 0);

    // Pending collect at 5, dropped collect at 6
    go();
    at(4);
    bus.collect = 1'b1;
    at(6);
    bus.collect = 1'b0;
    at(13); chk("p_cnt13", int'(bus.count), 1);
    at(25); chk("p_y25", int'(bus.y_pos), 40);
    at(26); chk("p_busy26", int'(bus.busy), 1);
    at(29); chk("p_y29", int'(bus.y_pos), 40);
    at(30); chk("p_y30", int'(bus.y_pos), 39);
    at(38); chk("p_y38", int'(bus.y_pos), 37);
    chk("p_cnt38", int'(bus.count), 1);
    at(39); chk("p_cnt39", int'(bus.count), 0);
    at(51); chk("p_y51", int'(bus.y_pos), 40);
    chk("p_busy51", int'(bus.busy), 1);
    at(52); chk("p_busy52", int'(bus.busy), 0);
    at(80); chk("p_busy80", int'(bus.busy), 0);
    chk("p_y80", int'(bus.y_pos), 40);

    // Set count to 1, then collect+clear together
    go();
    at(27); chk("c_pre_cnt", int'(bus.count), 1);
    bus.collect = 1'b1;
    bus.clear   = 1'b1;
    @(negedge clk);
    bus.collect = 1'b0;
    bus.clear   = 1'b0;
    chk("c_cnt", int'(bus.count), 0);
    chk("c_busy", int'(bus.busy), 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i % 10 == 9) begin
        chk("c_busy_hold", int'(bus.busy), 0);
        chk("c_y_hold", int'(bus.y_pos), 40);
        chk("c_cnt_hold", int'(bus.count), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
